// File: rtl/dram_unpack.sv
// dram_unpack: width-down converter from a 272-bit packed DRAM word to a stream of 16/32/48/64-bit slices.
// Optional feature macro DRAM_UNPACK_INV_EN: when defined, inv selects high-aligned slices; otherwise always low-aligned.
module dram_unpack #(
    parameter int WIDTH     = 272,
    parameter int WIDTH_OUT = 64,
    parameter int CNT_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [3:0]           len,
    input  logic                 inv,
    output logic [WIDTH_OUT-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 err
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SL64 = 2'd0,
        SL48 = 2'd1,
        SL32 = 2'd2,
        SL16 = 2'd3
    } slice_e;

    state_e                r_state;
    state_e                w_next;
    slice_e                r_sel;
    slice_e                w_sel_in;
    logic [WIDTH-1:0]      r_sreg;
    logic [WIDTH-1:0]      w_shifted;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [CNT_BITS-1:0]   w_cnt_in;
    logic                  r_inv;
    logic                  r_err;
    logic                  r_run;
    logic                  w_len_ok;
    logic                  w_inv_in;
    logic                  w_acc;
    logic                  w_xfer;
    logic                  w_cnt_zero;
    logic [WIDTH_OUT-1:0]  w_fmt;

`ifdef DRAM_UNPACK_INV_EN
    assign w_inv_in = inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = inv;
    assign w_inv_in     = 1'b0;
`endif

    // Handshakes; r_run holds din_ready low until the first edge after reset release.
    assign w_cnt_zero = (r_cnt == '0);
    assign dout_valid = (r_state == SEND) & ce;
    assign dout_last  = dout_valid & w_cnt_zero;
    assign din_ready  = ce & r_run & ((r_state == IDLE) | (dout_last & dout_ready));
    assign w_acc      = din_valid & din_ready;
    assign w_xfer     = dout_valid & dout_ready;
    assign err        = r_err;

    always_comb begin
        w_len_ok = 1'b1;
        w_sel_in = SL64;
        w_cnt_in = '0;
        case (len)
            4'd1:    begin w_sel_in = SL64; w_cnt_in = CNT_BITS'(4);  end
            4'd2:    begin w_sel_in = SL48; w_cnt_in = CNT_BITS'(5);  end
            4'd3:    begin w_sel_in = SL32; w_cnt_in = CNT_BITS'(8);  end
            4'd4:    begin w_sel_in = SL16; w_cnt_in = CNT_BITS'(16); end
            default: w_len_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_shifted = r_sreg >> 64;
        case (r_sel)
            SL64: w_shifted = r_sreg >> 64;
            SL48: w_shifted = r_sreg >> 48;
            SL32: w_shifted = r_sreg >> 32;
            SL16: w_shifted = r_sreg >> 16;
            default: w_shifted = r_sreg >> 64;
        endcase
    end

    // Zero fill from the shift leaves the tail of the final partial beat already cleared.
    always_comb begin
        w_fmt = r_sreg[WIDTH_OUT-1:0];
        case (r_sel)
            SL64: w_fmt = r_sreg[WIDTH_OUT-1:0];
            SL48: w_fmt = r_inv ? {r_sreg[47:0], {(WIDTH_OUT-48){1'b0}}}
                                : {{(WIDTH_OUT-48){1'b0}}, r_sreg[47:0]};
            SL32: w_fmt = r_inv ? {r_sreg[31:0], {(WIDTH_OUT-32){1'b0}}}
                                : {{(WIDTH_OUT-32){1'b0}}, r_sreg[31:0]};
            SL16: w_fmt = r_inv ? {r_sreg[15:0], {(WIDTH_OUT-16){1'b0}}}
                                : {{(WIDTH_OUT-16){1'b0}}, r_sreg[15:0]};
            default: w_fmt = r_sreg[WIDTH_OUT-1:0];
        endcase
    end

    assign dout = (r_state == SEND) ? w_fmt : '0;

    always_comb begin
        w_next = r_state;
        if (w_acc && w_len_ok) begin
            w_next = SEND;
        end else if (w_xfer && w_cnt_zero) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_sel  <= SL64;
            r_inv  <= 1'b0;
            r_err  <= 1'b0;
            r_run  <= 1'b0;
        end else if (ce) begin
            r_run <= 1'b1;
            r_err <= w_acc & ~w_len_ok;
            if (w_acc && w_len_ok) begin
                r_sreg <= din;
                r_cnt  <= w_cnt_in;
                r_sel  <= w_sel_in;
                r_inv  <= w_inv_in;
            end else if (w_xfer) begin
                r_sreg <= w_shifted;
                r_cnt  <= r_cnt - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_dram_unpack.sv
// Scoreboard bench for dram_unpack: expected beats come from an index-based slice model.
module tb_dram_unpack;

`ifdef DRAM_UNPACK_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         ce;
    logic [271:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [3:0]   len;
    logic         inv;
    logic [63:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] sb[$];

    dram_unpack #(.WIDTH(272), .WIDTH_OUT(64), .CNT_BITS(5)) dut (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .len(len), .inv(inv), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int l);
        case (l)
            1: return 64;
            2: return 48;
            3: return 32;
            default: return 16;
        endcase
    endfunction

    function automatic logic [63:0] exp_beat(input logic [271:0] word, input int w, input bit iv, input int i);
        logic [271:0] t;
        logic [63:0]  m;
        logic [63:0]  s;
        t = word >> (i * w);
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        s = t[63:0] & m;
        if (INV_EN && iv) s = s << (64 - w);
        return s;
    endfunction

    function automatic logic [271:0] inc_word();
        logic [271:0] r;
        r = '0;
        for (int k = 0; k < 17; k++) r[16*k +: 16] = 16'(k);
        return r;
    endfunction

    function automatic logic [271:0] rnd_word();
        logic [271:0] r;
        for (int k = 0; k < 17; k++) r[16*k +: 16] = 16'($urandom);
        return r;
    endfunction

    task automatic push_word(input logic [271:0] w, input int l, input bit iv);
        int wd;
        int nb;
        wd = wid(l);
        nb = (272 + wd - 1) / wd;
        for (int i = 0; i < nb; i++) sb.push_back({(i == nb - 1), exp_beat(w, wd, iv, i)});
    endtask

    // Presents a word until accepted, then scrambles len/inv/din to show they are ignored mid-word.
    task automatic offer(input logic [271:0] w, input int l, input bit iv, output bit ok);
        @(posedge clk); #1;
        din = w; len = 4'(l); inv = iv; din_valid = 1'b1; ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (din_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        din_valid = 1'b0; din = rnd_word(); len = 4'($urandom); inv = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1; din_valid = 1'b0; dout_ready = 1'b1; din = rnd_word(); len = 4'd4; inv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dout !== 64'd0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        n_checks++; if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_dout_last got=%b exp=0", dout_last); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got=%b exp=0", din_ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_din_ready got=%b exp=1", din_ready); end
    endtask

    task automatic test_len16();
        bit ok; int cyc; logic [64:0] e;
        push_word(inc_word(), 4, 1'b0);
        offer(inc_word(), 4, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL len16_accept got=0 exp=1"); end
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (dout_valid && dout_ready) begin
                e = sb.pop_front();
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL len16_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL len16_timeout got=%0d left exp=0", sb.size()); end
        n_checks++; if (cyc != 17) begin n_fail++; $display("FAIL len16_cycles got=%0d exp=17", cyc); end
        sb.delete();
    endtask

    task automatic test_len64();
        bit ok; int cyc; int idx; logic [64:0] e;
        push_word(inc_word(), 1, 1'b0);
        offer(inc_word(), 1, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL len64_accept got=0 exp=1"); end
        cyc = 0; idx = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (dout_valid && dout_ready) begin
                e = sb.pop_front();
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL len64_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
                if (idx == 0) begin
                    n_checks++; if (dout !== 64'h0003_0002_0001_0000) begin n_fail++; $display("FAIL len64_first got=%h exp=0003000200010000", dout); end
                end
                if (idx == 4) begin
                    n_checks++; if (dout !== 64'h0000_0000_0000_0010) begin n_fail++; $display("FAIL len64_last got=%h exp=0000000000000010", dout); end
                end
                idx++;
            end
        end
        n_checks++; if (sb.size() != 0 || cyc != 5) begin n_fail++; $display("FAIL len64_timing got=%0d cycles exp=5", cyc); end
        sb.delete();
    endtask

    task automatic test_inv();
        int lens[4] = '{3, 2, 4, 1};
        bit ok; int cyc; int idx; logic [64:0] e; logic [271:0] w; logic [63:0] b0;
        b0 = INV_EN ? 64'hDEADBEEF_00000000 : 64'h00000000_DEADBEEF;
        foreach (lens[j]) begin
            w = rnd_word();
            if (lens[j] == 3) w[31:0] = 32'hDEADBEEF;
            push_word(w, lens[j], 1'b1);
            offer(w, lens[j], 1'b1, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL inv_accept len=%0d got=0 exp=1", lens[j]); end
            cyc = 0; idx = 0;
            while (sb.size() > 0 && cyc < 200) begin
                @(negedge clk); cyc++;
                if (dout_valid && dout_ready) begin
                    e = sb.pop_front();
                    n_checks++;
                    if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL inv_beat len=%0d got=%b_%h exp=%b_%h", lens[j], dout_last, dout, e[64], e[63:0]); end
                    if (lens[j] == 3 && idx == 0) begin
                        n_checks++; if (dout !== b0) begin n_fail++; $display("FAIL inv_deadbeef got=%h exp=%h", dout, b0); end
                    end
                    idx++;
                end
            end
            n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL inv_timeout got=%0d left exp=0", sb.size()); end
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [271:0] w1, w2; int acc, popped, cyc, rdy_hi; logic [64:0] e, held; bit stall, pushed2;
        w1 = rnd_word(); w2 = rnd_word();
        @(posedge clk); #1;
        push_word(w1, 2, 1'b0);
        din = w1; len = 4'd2; inv = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
        acc = 0; popped = 0; cyc = 0; rdy_hi = 0; stall = 1'b0; pushed2 = 1'b0; held = '0;
        while (popped < 12 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (stall) begin
                n_checks++;
                if ({dout_valid, dout_last, dout} !== {1'b1, held}) begin n_fail++; $display("FAIL b2b_stall got=%b_%b_%h exp=1_%b_%h", dout_valid, dout_last, dout, held[64], held[63:0]); end
            end
            stall = dout_valid && !dout_ready;
            held  = {dout_last, dout};
            if (acc == 1 && din_valid && din_ready) begin
                rdy_hi++;
                n_checks++;
                if (popped != 5 || !dout_ready) begin n_fail++; $display("FAIL b2b_ready_timing got=%0d beats exp=5", popped); end
            end
            if (dout_valid && dout_ready) begin
                e = sb.pop_front(); popped++;
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL b2b_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
            end
            if (din_valid && din_ready) acc++;
            @(posedge clk); #1;
            if (acc == 1 && !pushed2) begin push_word(w2, 2, 1'b0); din = w2; pushed2 = 1'b1; end
            if (acc == 2) din_valid = 1'b0;
            dout_ready = ~dout_ready;
        end
        dout_ready = 1'b1;
        n_checks++; if (popped != 12) begin n_fail++; $display("FAIL b2b_beats got=%0d exp=12", popped); end
        n_checks++; if (rdy_hi != 1 || acc != 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d/%0d exp=1/2", rdy_hi, acc); end
        sb.delete();
    endtask

    task automatic test_invalid();
        bit ok; int cyc; int vcnt; logic [64:0] e;
        @(posedge clk); #1;
        din = rnd_word(); len = 4'd7; inv = 1'b0; din_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL invalid_ready got=%b exp=1", din_ready); end
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL invalid_err_pulse got=%b exp=1", err); end
        vcnt = dout_valid ? 1 : 0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL invalid_err_clear got=%b exp=0", err); end
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (dout_valid) vcnt++; end
        n_checks++; if (vcnt != 0) begin n_fail++; $display("FAIL invalid_no_valid got=%0d exp=0", vcnt); end
        push_word(inc_word(), 4, 1'b0);
        offer(inc_word(), 4, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL after_invalid_accept got=0 exp=1"); end
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (dout_valid && dout_ready) begin
                e = sb.pop_front();
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL after_invalid_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL after_invalid_timeout got=%0d left exp=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_ce_freeze();
        bit ok; int cyc; int popped; logic [64:0] e; logic [271:0] w;
        w = rnd_word();
        push_word(w, 2, 1'b0);
        offer(w, 2, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ce_accept got=0 exp=1"); end
        cyc = 0; popped = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (dout_valid && dout_ready) begin
                e = sb.pop_front(); popped++;
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL ce_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
            end
            if (popped == 2 && ce) begin
                @(posedge clk); #1 ce = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (dout_valid !== 1'b0 || din_ready !== 1'b0) begin n_fail++; $display("FAIL ce_low_outputs got=%b%b exp=00", dout_valid, din_ready); end
                end
                @(posedge clk); #1 ce = 1'b1;
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL ce_timeout got=%0d left exp=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; int popped; logic [64:0] e; logic [271:0] w;
        push_word(inc_word(), 4, 1'b0);
        offer(inc_word(), 4, 1'b0, ok);
        cyc = 0; popped = 0;
        while (popped < 3 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (dout_valid && dout_ready) begin
                e = sb.pop_front(); popped++;
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL rstmid_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        #1;
        n_checks++;
        if (dout_valid !== 1'b0 || dout !== 64'd0 || dout_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs got=%b_%b_%h exp=0_0_0", dout_valid, dout_last, dout); end
        sb.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_partial got=%b exp=0", dout_valid); end
        w = rnd_word();
        push_word(w, 3, 1'b0);
        offer(w, 3, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_accept got=0 exp=1"); end
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (dout_valid && dout_ready) begin
                e = sb.pop_front();
                n_checks++;
                if ({dout_last, dout} !== e) begin n_fail++; $display("FAIL rstmid_next_beat got=%b_%h exp=%b_%h", dout_last, dout, e[64], e[63:0]); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rstmid_timeout got=%0d left exp=0", sb.size()); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_len16();
        test_len64();
        test_inv();
        test_back_to_back();
        test_invalid();
        test_ce_freeze();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
